// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline stage: carries load data, ALU result and destination register toward writeback.
// Latency 1 cycle (accept in N, visible in N+1); two-entry skid buffer sustains 1 payload/cycle.
// Backpressure: in_ready is registered from next state and drops only while both entries are full.
// Optional stall counter is built only when WB_PIPE_STALL_CNT_EN is defined; otherwise stall_cnt is 0.
module wb_pipe_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_write_register,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_write_register,
  output logic              out_reg_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q;
  logic                load_main, load_skid, skid_to_main;
  logic                accept, consume, main_vld;

  logic [DATA_W-1:0]   main_rd_q, main_alu_q, skid_rd_q, skid_alu_q;
  logic [REG_W-1:0]    main_wr_q, skid_wr_q;
  logic                main_rw_q, skid_rw_q;

  assign main_vld = (state_q != EMPTY);
  assign accept   = in_valid && in_ready_q;
  assign consume  = main_vld && out_ready;

  // Next-state and load-enable decode; flush overrides every handshake.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (consume) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          skid_to_main = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // State, registered ready and payload storage; payload only moves on accept or skid transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_rd_q  <= '0;
      main_alu_q <= '0;
      main_wr_q  <= '0;
      main_rw_q  <= 1'b0;
      skid_rd_q  <= '0;
      skid_alu_q <= '0;
      skid_wr_q  <= '0;
      skid_rw_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main) begin
        main_rd_q  <= in_read_data;
        main_alu_q <= in_alu_result;
        main_wr_q  <= in_write_register;
        main_rw_q  <= in_reg_write;
      end else if (skid_to_main) begin
        main_rd_q  <= skid_rd_q;
        main_alu_q <= skid_alu_q;
        main_wr_q  <= skid_wr_q;
        main_rw_q  <= skid_rw_q;
      end
      if (load_skid) begin
        skid_rd_q  <= in_read_data;
        skid_alu_q <= in_alu_result;
        skid_wr_q  <= in_write_register;
        skid_rw_q  <= in_reg_write;
      end
    end
  end

  assign in_ready           = in_ready_q;
  assign out_valid          = main_vld;
  assign out_read_data      = main_rd_q;
  assign out_alu_result     = main_alu_q;
  assign out_write_register = main_wr_q;
  // A bubble must never write the register file, whatever the stale payload says.
  assign out_reg_write      = main_rw_q && main_vld;

`ifdef WB_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count cycles where WB holds off a valid payload; saturate, cleared by reset only.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (main_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Testbench for wb_pipe_stage: directed scenarios plus randomized traffic against a FIFO-level model.
// Inputs are driven on the falling edge; outputs are compared on the following falling edge.
// Model treats the stage as a depth-2 queue whose ready reflects the post-update occupancy.
module tb_wb_pipe_stage;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wr;
    logic              rw;
  } pl_t;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_read_data, in_alu_result, out_read_data, out_alu_result;
  logic [REG_W-1:0]  in_write_register, out_write_register;
  logic              in_reg_write, out_reg_write;
  logic [CNT_W-1:0]  stall_cnt;

  wb_pipe_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_read_data       (in_read_data),
    .in_alu_result      (in_alu_result),
    .in_write_register  (in_write_register),
    .in_reg_write       (in_reg_write),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_read_data      (out_read_data),
    .out_alu_result     (out_alu_result),
    .out_write_register (out_write_register),
    .out_reg_write      (out_reg_write),
    .stall_cnt          (stall_cnt)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;

  pl_t  q[$];
  pl_t  shown;
  logic m_rdy;
  int   m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pl_t mk(input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr, input logic rw);
    pl_t p;
    p.rd  = {$urandom, $urandom};
    p.alu = alu;
    p.wr  = wr;
    p.rw  = rw;
    return p;
  endfunction

  task automatic check_outputs();
    logic [63:0] exp_stall;
`ifdef WB_PIPE_STALL_CNT_EN
    exp_stall = 64'(m_stall);
`else
    exp_stall = 64'd0;
`endif
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("out_read_data", 64'(out_read_data), 64'(shown.rd));
    check("out_alu_result", 64'(out_alu_result), 64'(shown.alu));
    check("out_write_register", 64'(out_write_register), 64'(shown.wr));
    check("out_reg_write", 64'(out_reg_write), 64'((q.size() > 0) ? q[0].rw : 1'b0));
    check("stall_cnt", 64'(stall_cnt), exp_stall);
  endtask

  // One clock: drive at the falling edge, advance the model, compare at the next falling edge.
  task automatic step(input logic rst, input logic fl, input logic iv, input pl_t p, input logic ordy);
    logic acc, con;
    reset             = rst;
    flush             = fl;
    in_valid          = iv;
    in_read_data      = p.rd;
    in_alu_result     = p.alu;
    in_write_register = p.wr;
    in_reg_write      = p.rw;
    out_ready         = ordy;
    if (rst) begin
      q.delete();
      m_rdy   = 1'b1;
      shown   = '0;
      m_stall = 0;
    end else begin
      acc = iv && m_rdy;
      con = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && m_stall < STALL_MAX) m_stall++;
      if (con) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) q.push_back(p);
      m_rdy = (q.size() < 2);
      if (q.size() > 0) shown = q[0];
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, mk(64'hBAD, 5'd31, 1'b1), 1'b1);
  endtask

  initial begin
    pl_t p;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_read_data = '0; in_alu_result = '0; in_write_register = '0; in_reg_write = 1'b0;
    shown = '0; m_rdy = 1'b1; m_stall = 0;
    @(negedge clock);

    // Reset held two cycles with in_valid asserted.
    step(1'b1, 1'b0, 1'b1, mk(64'h55, 5'd3, 1'b1), 1'b1);
    step(1'b1, 1'b0, 1'b1, mk(64'h55, 5'd3, 1'b1), 1'b1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_alu", 64'(out_alu_result), 64'd0);
    check("reset_rd", 64'(out_read_data), 64'd0);
    step(1'b0, 1'b0, 1'b1, mk(64'h77, 5'd9, 1'b1), 1'b1);
    check("first_accept_alu", 64'(out_alu_result), 64'h77);
    check("first_accept_valid", 64'(out_valid), 64'd1);
    idle(2);

    // Streaming, 8 back-to-back payloads.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, mk(64'(16 + i), 5'(i + 1), 1'b1), 1'b1);
      check("stream_alu", 64'(out_alu_result), 64'(16 + i));
      check("stream_wr", 64'(out_write_register), 64'(i + 1));
    end
    idle(2);

    // Back-pressure: three cycles of out_ready low with a valid head.
    step(1'b1, 1'b0, 1'b0, mk(64'h0, 5'd0, 1'b0), 1'b1);
    step(1'b0, 1'b0, 1'b1, mk(64'h20, 5'd1, 1'b1), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, mk(64'(33 + i), 5'(2 + i), 1'b1), 1'b0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, mk(64'(48 + i), 5'(10 + i), 1'b0), 1'b1);
`ifdef WB_PIPE_STALL_CNT_EN
    check("bp_stall_cnt", 64'(stall_cnt), 64'd3);
`else
    check("bp_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    idle(3);

    // Flush while TWO with a simultaneous input.
    step(1'b0, 1'b0, 1'b1, mk(64'h61, 5'd4, 1'b1), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(64'h62, 5'd5, 1'b1), 1'b0);
    step(1'b0, 1'b1, 1'b1, mk(64'hDEAD, 5'd6, 1'b1), 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_reg_write", 64'(out_reg_write), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, mk(64'h0, 5'd0, 1'b0), 1'b1);
      check("flush_dropped", 64'(out_valid), 64'd0);
    end

    // Bubble gating of reg_write.
    step(1'b0, 1'b0, 1'b1, mk(64'h70, 5'd7, 1'b1), 1'b1);
    step(1'b0, 1'b0, 1'b0, mk(64'h0, 5'd0, 1'b0), 1'b1);
    check("bubble_reg_write", 64'(out_reg_write), 64'd0);
    check("bubble_wr_held", 64'(out_write_register), 64'd7);

`ifdef WB_PIPE_STALL_CNT_EN
    // Saturation: long stall on a 4-bit counter.
    step(1'b1, 1'b0, 1'b0, mk(64'h0, 5'd0, 1'b0), 1'b1);
    step(1'b0, 1'b0, 1'b1, mk(64'h80, 5'd8, 1'b1), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, mk(64'h0, 5'd0, 1'b0), 1'b0);
    check("stall_saturate", 64'(stall_cnt), 64'd15);
    idle(2);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      p = mk({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
